uart_tx_frame4: RTL and testbench

Serial transmitter that produces the team's UART frame format, the upstream counterpart of the 4-byte receiver stage. It latches a 4-byte message and serialises the bytes in order 0..3 on a single line, one bit per iCE tick. Each byte frame is:
- start bit (high, line idles low)
- 8 data bits, LSB first
- even-parity bit (XOR of the data bits)
- stop bit (low)
- guard bit(s) (low)

The receiver can therefore restart on the tick immediately after its end-of-frame cycle.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 94 +++++++++
 rtl/uart_tx_frame4.sv | 93 +++++++++
 tb/tb_uart_tx_frame4.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and frame sizes
// used by both the transmitter and the 4-byte receiver stage.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GUARD
    } uart_state_t;

    localparam logic UART_START_LEVEL = 1'b1;
    localparam logic UART_IDLE_LEVEL  = ~UART_START_LEVEL;

    localparam int DATA_BITS       = 8;
    localparam int FRAME_CORE_BITS = 11;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-frame serialiser: start, 8 data LSB first, even parity, stop,
// guard. A new byte may be loaded on the tick that ends the last guard bit.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int   GUARD_BITS  = 1,
    parameter logic START_LEVEL = UART_START_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       par_flip,
    output logic       line,
    output logic       busy,
    output logic       ready
);

    localparam logic       IDLE_LVL   = ~START_LEVEL;
    localparam logic [1:0] GUARD_LAST = 2'(GUARD_BITS - 1);
    localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [7:0]  shift;
    logic        parity;
    logic [2:0]  bit_cnt;
    logic [1:0]  guard_cnt;

    assign busy  = (state != ST_IDLE);
    // Ready also covers the final guard tick so frames chain without a gap.
    assign ready = (state == ST_IDLE) ||
                   ((state == ST_GUARD) && (guard_cnt == GUARD_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            line      <= IDLE_LVL;
            shift     <= '0;
            parity    <= 1'b0;
            bit_cnt   <= '0;
            guard_cnt <= '0;
        end else if (ce) begin
            if (ready) begin
                guard_cnt <= '0;
                if (load) begin
                    state  <= ST_START;
                    line   <= START_LEVEL;
                    shift  <= data;
                    parity <= (^data) ^ par_flip;
                end else begin
                    state <= ST_IDLE;
                    line  <= IDLE_LVL;
                end
            end else begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        line    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_PARITY;
                            line  <= parity;
                        end else begin
                            line  <= shift[0];
                            shift <= shift >> 1;
                        end
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        line  <= IDLE_LVL;
                    end
                    ST_STOP: begin
                        state     <= ST_GUARD;
                        line      <= IDLE_LVL;
                        guard_cnt <= '0;
                    end
                    ST_GUARD: begin
                        guard_cnt <= guard_cnt + 2'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        line  <= IDLE_LVL;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame4.sv
// 4-byte UART message transmitter; bytes 0..3 go out back to back.
// Optional UART_TX_PARITY_ERR_INJ_EN adds iErrInj to corrupt byte 0 parity.
module uart_tx_frame4
    import uart_pkg::*;
#(
    parameter int   GUARD_BITS  = 1,
    parameter logic START_LEVEL = UART_START_LEVEL
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCE,
    input  logic       iStart,
`ifdef UART_TX_PARITY_ERR_INJ_EN
    input  logic       iErrInj,
`endif
    input  logic [7:0] ivCarga0,
    input  logic [7:0] ivCarga1,
    input  logic [7:0] ivCarga2,
    input  logic [7:0] ivCarga3,
    output logic       oDatos,
    output logic       oBusy,
    output logic       oDone
);

    logic [3:0][7:0] buffer;
    logic [1:0]      index;
    logic [1:0]      sel;
    logic            tx_busy;
    logic            tx_ready;
    logic            at_end;
    logic            last;
    logic            load;
    logic            flip;

    assign at_end = tx_busy & tx_ready;
    assign last   = at_end & (index == 2'd3);
    // At a frame end the next byte is handed over on the same tick.
    assign sel    = at_end ? index + 2'd1 : index;
    assign load   = oBusy & tx_ready & ~last;

`ifdef UART_TX_PARITY_ERR_INJ_EN
    logic err_inj;
    assign flip = err_inj & (sel == 2'd0);

    always_ff @(posedge iClk) begin
        if (iReset)
            err_inj <= 1'b0;
        else if (!oBusy && iStart)
            err_inj <= iErrInj;
    end
`else
    assign flip = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            buffer <= '0;
            index  <= '0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (!oBusy && iStart) begin
                buffer <= {ivCarga3, ivCarga2, ivCarga1, ivCarga0};
                oBusy  <= 1'b1;
            end else if (iCE && at_end && oBusy) begin
                if (last) begin
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                    index <= '0;
                end else begin
                    index <= index + 2'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .GUARD_BITS (GUARD_BITS),
        .START_LEVEL(START_LEVEL)
    ) u_byte (
        .clk     (iClk),
        .reset   (iReset),
        .ce      (iCE),
        .load    (load),
        .data    (buffer[sel]),
        .par_flip(flip),
        .line    (oDatos),
        .busy    (tx_busy),
        .ready   (tx_ready)
    );

endmodule

// File: tb/tb_uart_tx_frame4.sv
// Bench for uart_tx_frame4: expected line bits are queued per message
// and popped on every iCE tick.
module tb_uart_tx_frame4;
    import uart_pkg::*;

    localparam int GUARD_BITS = 1;
    localparam int FRAME      = FRAME_CORE_BITS + GUARD_BITS;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       ce    = 1'b0;
    logic       start = 1'b0;
    logic [7:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;
    logic       line, busy, done;
`ifdef UART_TX_PARITY_ERR_INJ_EN
    logic       err_inj = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit obs_q[$];

    always #5 clk = ~clk;

    uart_tx_frame4 #(.GUARD_BITS(GUARD_BITS)) dut (
        .iClk    (clk),
        .iReset  (rst),
        .iCE     (ce),
        .iStart  (start),
`ifdef UART_TX_PARITY_ERR_INJ_EN
        .iErrInj (err_inj),
`endif
        .ivCarga0(c0),
        .ivCarga1(c1),
        .ivCarga2(c2),
        .ivCarga3(c3),
        .oDatos  (line),
        .oBusy   (busy),
        .oDone   (done)
    );

    task automatic step(input logic st, input logic c);
        start = st;
        ce    = c;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b0;
    endtask

    task automatic set_msg(input logic [31:0] m);
        c0 = m[7:0];
        c1 = m[15:8];
        c2 = m[23:16];
        c3 = m[31:24];
    endtask

    task automatic push_msg(input logic [31:0] m, input bit flip0);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = m[8*i +: 8];
            exp_q.push_back(1'b1);
            for (int j = 0; j < DATA_BITS; j++) exp_q.push_back(b[j]);
            exp_q.push_back((^b) ^ (flip0 && i == 0));
            exp_q.push_back(1'b0);
            for (int g = 0; g < GUARD_BITS; g++) exp_q.push_back(1'b0);
        end
    endtask

    // ev_kind 1: iStart with ev_data after tick ev_tick; 2: reset there
    task automatic drain(input string tag, input int period,
                         input int ev_tick, input int ev_kind,
                         input logic [31:0] ev_data);
        int k     = 0;
        int ticks = 0;
        int dones = 0;
        bit c;
        bit e;
        bit fire  = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            c = (k % period) == (period - 1);
            k++;
            if (fire && ev_kind == 2) begin
                rst = 1'b1;
                step(1'b0, c);
                rst = 1'b0;
                n_checks++;
                if (line !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort: line=%b busy=%b, need 0 0",
                             tag, line, busy);
                end
                exp_q.delete();
                return;
            end
            if (fire) set_msg(ev_data);
            step(fire, c);
            fire = 0;
            if (done === 1'b1) dones++;
            if (c) begin
                e = exp_q.pop_front();
                ticks++;
                obs_q.push_back(line);
                n_checks++;
                if (line !== e) begin
                    n_fail++;
                    $display("FAIL %s line tick %0d: got %b, need %b",
                             tag, ticks, line, e);
                end
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy tick %0d: got %b, need 1",
                             tag, ticks, busy);
                end
                if (ticks == ev_tick) fire = 1;
            end
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d bits left", tag, exp_q.size());
            exp_q.delete();
            return;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL %s early done: got %0d pulses, need 0", tag, dones);
        end
        k = 0;
        c = 0;
        while (!c && k < period + 2) begin
            c = (k % period) == (period - 1);
            k++;
            step(1'b0, c);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || line !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: done=%b busy=%b line=%b, need 1 0 0",
                     tag, done, busy, line);
        end
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (line !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: line=%b busy=%b done=%b, need 0 0 0",
                     tag, line, busy, done);
        end
    endtask

    task automatic check_accept(input string tag);
        n_checks++;
        if (busy !== 1'b1 || line !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b line=%b done=%b, need 1 0 0",
                     tag, busy, line, done);
        end
    endtask

    task automatic test_reset();
        set_msg(32'hFF0007A5);
        rst = 1'b1;
        step(1'b1, 1'b1);
        check_idle("reset clk1");
        step(1'b0, 1'b1);
        check_idle("reset clk2");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check_idle("post reset");
        end
    endtask

    task automatic test_message();
        set_msg(32'hFF0007A5);
        step(1'b1, 1'b0);
        check_accept("msg");
        push_msg(32'hFF0007A5, 1'b0);
        drain("msg", 4, -1, 0, '0);
        step(1'b0, 1'b0);
        check_idle("msg after done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [31:0] m;
        m = 32'hFF0007A5;
        set_msg(m);
        step(1'b1, 1'b1);
        check_accept("b2b start+ce");
        push_msg(m, 1'b0);
        obs_q.delete();
        drain("b2b", 1, -1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) got[j] = obs_q[i*FRAME + 1 + j];
            n_checks++;
            if (got !== m[8*i +: 8]) begin
                n_fail++;
                $display("FAIL loop byte %0d: got %h, need %h",
                         i, got, m[8*i +: 8]);
            end
        end
        m = 32'h44434241;
        set_msg(m);
        step(1'b1, 1'b0);
        check_accept("b2b restart on done");
        push_msg(m, 1'b0);
        drain("b2b second", 1, -1, 0, '0);
        step(1'b0, 1'b0);
        check_idle("b2b after done");
    endtask

    task automatic test_busy_ignore();
        set_msg(32'hFF0007A5);
        step(1'b1, 1'b0);
        check_accept("ignore");
        push_msg(32'hFF0007A5, 1'b0);
        drain("ignore", 4, 5, 1, 32'h44332211);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check_idle("ignore no resend");
        end
    endtask

    task automatic test_reset_abort();
        set_msg(32'hFF0007A5);
        step(1'b1, 1'b0);
        check_accept("abort");
        push_msg(32'hFF0007A5, 1'b0);
        drain("abort", 2, FRAME + 5, 2, '0);
        step(1'b0, 1'b1);
        check_idle("abort idle");
        set_msg(32'h44434241);
        step(1'b1, 1'b0);
        check_accept("after abort");
        push_msg(32'h44434241, 1'b0);
        drain("after abort", 2, -1, 0, '0);
        step(1'b0, 1'b0);
        check_idle("after abort done");
    endtask

`ifdef UART_TX_PARITY_ERR_INJ_EN
    task automatic test_parity_inj();
        set_msg(32'h44430707);
        err_inj = 1'b1;
        step(1'b1, 1'b0);
        err_inj = 1'b0;
        check_accept("inj");
        push_msg(32'h44430707, 1'b1);
        drain("inj", 3, -1, 0, '0);
        step(1'b0, 1'b0);
        check_idle("inj after done");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_message();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
`ifdef UART_TX_PARITY_ERR_INJ_EN
        test_parity_inj();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
